// File: rtl/mux_8to1.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mux_8to1                                                              |
// | One-of-eight selector with combinational output plus a registered     |
// | copy (value, select code, change pulse). Optional macro:              |
// | MUX_8TO1_ONEHOT_EN adds a combinational one-hot decode of the select. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module mux_8to1 #(
   parameter int DATA_W = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] I0,
   input  logic [DATA_W-1:0] I1,
   input  logic [DATA_W-1:0] I2,
   input  logic [DATA_W-1:0] I3,
   input  logic [DATA_W-1:0] I4,
   input  logic [DATA_W-1:0] I5,
   input  logic [DATA_W-1:0] I6,
   input  logic [DATA_W-1:0] I7,
   input  logic              B0,
   input  logic              B1,
   input  logic              B2,
   output logic [DATA_W-1:0] O,
   output logic [DATA_W-1:0] O_q,
   output logic [2:0]        sel_q,
   output logic              chg
`ifdef MUX_8TO1_ONEHOT_EN
   ,
   output logic [7:0]        sel_onehot
`endif
);

   logic [2:0]        w_sel;
   logic [DATA_W-1:0] o_d;
   logic [2:0]        sel_d;
   logic              chg_d;
   logic              chg_q;

   assign w_sel = {B2, B1, B0};

   // An unknown select bit matches no code and falls through to X.
   always_comb begin
      O = '0;
      case (w_sel)
         3'd0:    O = I0;
         3'd1:    O = I1;
         3'd2:    O = I2;
         3'd3:    O = I3;
         3'd4:    O = I4;
         3'd5:    O = I5;
         3'd6:    O = I6;
         3'd7:    O = I7;
         default: O = 'x;
      endcase
   end

   // chg looks at the value about to be loaded against what O_q holds now.
   always_comb begin
      o_d   = O;
      sel_d = w_sel;
      chg_d = (O != O_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         O_q   <= '0;
         sel_q <= 3'b000;
         chg_q <= 1'b0;
      end else begin
         O_q   <= o_d;
         sel_q <= sel_d;
         chg_q <= chg_d;
      end
   end

   assign chg = chg_q;

`ifdef MUX_8TO1_ONEHOT_EN
   always_comb begin
      sel_onehot = 8'h00;
      case (w_sel)
         3'd0:    sel_onehot = 8'h01;
         3'd1:    sel_onehot = 8'h02;
         3'd2:    sel_onehot = 8'h04;
         3'd3:    sel_onehot = 8'h08;
         3'd4:    sel_onehot = 8'h10;
         3'd5:    sel_onehot = 8'h20;
         3'd6:    sel_onehot = 8'h40;
         3'd7:    sel_onehot = 8'h80;
         default: sel_onehot = 8'h00;
      endcase
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_8to1.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mux_8to1                                                           |
// | Scoreboard bench for mux_8to1: random and directed vectors against a  |
// | bit-indexing reference model. Macro: MUX_8TO1_ONEHOT_EN.              |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_mux_8to1;

   typedef struct {
      string      name;
      int         kind;   // 0:O 1:O_q 2:sel_q 3:chg 4:sel_onehot
      logic [7:0] exp;
   } sb_entry_t;

   logic       clk;
   logic       rst_n;
   logic [7:0] data;
   logic [2:0] s;
   logic       o_w, o_q_w, chg_w;
   logic [2:0] sel_q_w;
`ifdef MUX_8TO1_ONEHOT_EN
   logic [7:0] onehot_w;
`endif

   sb_entry_t  sb[$];
   event       chk_ev;
   int         errors = 0;
   int         checks = 0;
   logic       m_oq;

   mux_8to1 #(.DATA_W(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .I0    (data[0]),
      .I1    (data[1]),
      .I2    (data[2]),
      .I3    (data[3]),
      .I4    (data[4]),
      .I5    (data[5]),
      .I6    (data[6]),
      .I7    (data[7]),
      .B0    (s[0]),
      .B1    (s[1]),
      .B2    (s[2]),
      .O     (o_w),
      .O_q   (o_q_w),
      .sel_q (sel_q_w),
      .chg   (chg_w)
`ifdef MUX_8TO1_ONEHOT_EN
      ,
      .sel_onehot (onehot_w)
`endif
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Monitor: drains the scoreboard whenever the stimulus signals a sample point.
   initial begin
      sb_entry_t  e;
      logic [7:0] act;
      forever begin
         @(chk_ev);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
               0: act = {7'b0, o_w};
               1: act = {7'b0, o_q_w};
               2: act = {5'b0, sel_q_w};
               3: act = {7'b0, chg_w};
`ifdef MUX_8TO1_ONEHOT_EN
               4: act = onehot_w;
`endif
               default: act = 8'hxx;
            endcase
            checks++;
            if (act !== e.exp) begin
               errors++;
               $display("FAIL %s: got %h expected %h (data=%h s=%0d t=%0t)",
                        e.name, act, e.exp, data, s, $time);
            end
         end
      end
   end

   task automatic push(input string name, input int kind, input logic [7:0] exp);
      sb_entry_t e;
      e.name = name;
      e.kind = kind;
      e.exp  = exp;
      sb.push_back(e);
   endtask

   // Applies one vector one ns after a falling edge; the window spans exactly
   // one rising edge, so the register model advances once per call.
   task automatic apply(input logic [7:0] d, input logic [2:0] sel, input string tag);
      logic       bit_sel;
      logic       exp_chg;
      data = d;
      s    = sel;
      #19;
      bit_sel = d[sel];
      push({tag, ".O"}, 0, {7'b0, bit_sel});
      if (rst_n) begin
         exp_chg = (bit_sel != m_oq);
         m_oq    = bit_sel;
         push({tag, ".O_q"},   1, {7'b0, bit_sel});
         push({tag, ".sel_q"}, 2, {5'b0, sel});
         push({tag, ".chg"},   3, {7'b0, exp_chg});
      end else begin
         m_oq = 1'b0;
         push({tag, ".O_q"},   1, 8'h00);
         push({tag, ".sel_q"}, 2, 8'h00);
         push({tag, ".chg"},   3, 8'h00);
      end
`ifdef MUX_8TO1_ONEHOT_EN
      push({tag, ".onehot"}, 4, 8'(1 << sel));
`endif
      -> chk_ev;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] oh;
      rst_n = 1'b0;
      data  = 8'h00;
      s     = 3'd0;
      m_oq  = 1'b0;
      #5;
      push("reset.O_q",   1, 8'h00);
      push("reset.sel_q", 2, 8'h00);
      push("reset.chg",   3, 8'h00);
      push("reset.O",     0, 8'h00);
      -> chk_ev;
      #1;

      // Combinational path must work while reset is held.
      @(negedge clk); #1;
      apply(8'h01, 3'd0, "in_reset");
      apply(8'h40, 3'd6, "in_reset6");

      rst_n = 1'b1;
      apply(8'h80, 3'd7, "latency1");
      apply(8'h80, 3'd7, "latency2");

      // Asynchronous reset mid-cycle, away from any clock edge.
      #4;
      rst_n = 1'b0;
      #1;
      push("async.O_q",   1, 8'h00);
      push("async.sel_q", 2, 8'h00);
      push("async.chg",   3, 8'h00);
      push("async.O",     0, 8'h01);
      -> chk_ev;
      #1;
      m_oq = 1'b0;
      @(negedge clk); #1;
      apply(8'h80, 3'd7, "async_hold");
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         oh = 8'h01 << i;
         apply(oh, 3'(i), "onehot_data");
         apply(~oh, 3'(i), "onehot_inv");
      end

      apply(8'h0F, 3'd3, "selonly3");
      apply(8'h0F, 3'd4, "selonly4");
      apply(8'h0F, 3'd4, "selonly4b");

      apply(8'hA5, 3'd2, "a5_s2");
      apply(8'hA5, 3'd1, "a5_s1");

      for (int i = 0; i < 200; i++) begin
         apply(8'($urandom), 3'($urandom_range(0, 7)), "random");
      end

      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mux_8to1.md
Name: mux_8to1

Overview:
- 8-input, one-of-eight selector. Output O is driven combinationally by the input chosen by the 3-bit select {B2,B1,B0}.
- A registered copy of the result is also provided for synchronous consumers: selected value, latched select code and a change pulse.
- Leaf datapath block used wherever a bit (or narrow field) must be picked from eight sources by a binary code.

Parameters:
- DATA_W, 1, width of each data input I0..I7 and of O / O_q.

Ports:
- clk  input  1  system clock; all registered outputs update on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- I0..I7  input  DATA_W each  data inputs; I0 is index 0, I7 is index 7.
- B0  input  1  select bit 0 (LSB).
- B1  input  1  select bit 1.
- B2  input  1  select bit 2 (MSB).
- O  output  DATA_W  combinational selected data.
- O_q  output  DATA_W  registered selected data.
- sel_q  output  3  registered select code {B2,B1,B0}.
- chg  output  1  one-cycle pulse when O_q takes a new value.

Behaviour:
- Select code s = {B2,B1,B0}, unsigned 0..7.
- O = I[s]: s=0 gives I0, s=1 gives I1, and so on up to s=7 giving I7.
- O is purely combinational. It has no dependence on clk or rst_n and is valid within the same delta as any input or select change, including before the first clock edge and during reset.
- All eight codes are legal; there is no default or illegal code.
- If any select bit is X/Z, O is X.
- Registered path:
  - On rising clk with rst_n=1: O_q <= I[s]; sel_q <= s; chg <= (I[s] != O_q).
  - O_q therefore reflects the inputs present at the previous rising edge (1-cycle latency).
  - chg compares the new selected value against the current O_q, so it is high for exactly the cycle after the edge on which O_q changed.
- Reset: while rst_n=0, O_q=0, sel_q=3'b000 and chg=0, asserted asynchronously without waiting for clk. O is unaffected by reset.
- Reset release: the first rising edge after rst_n goes high loads normally. chg on that edge is 1 if the selected value is nonzero (compared against the reset value 0).
- Reset asserted mid-operation clears the registers immediately. The combinational output keeps tracking the inputs.
- Select and data changing together: O settles to the new I[new s]. No glitch-free guarantee is required on O; O_q is glitch-free by construction.

Optional Feature:
- Macro MUX_8TO1_ONEHOT_EN.
- When defined: extra output sel_onehot, 8 bits, combinational, equal to 1 shifted left by s (s=5 gives 8'b0010_0000). All-zero if any select bit is X/Z.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Exhaustive select, one-hot data: for s=0..7 drive {I7..I0}=8'h01<<s, wait 20 ns -> O=1. Then drive {I7..I0}=~(8'h01<<s) -> O=0.
- Random: 200 vectors, {I7..I0}=random 8-bit, s=random 0..7, check 20 ns after apply -> O equals bit s of the data (e.g. data 8'hA5, s=2 -> O=1; s=1 -> O=0). Expect 0 errors.
- Registered latency: after reset, data 8'h80, s=7. First edge -> O_q=1, sel_q=7, chg=1. Next edge with no change -> chg=0, O_q=1.
- Async reset: assert rst_n=0 mid-cycle while O_q=1 -> O_q=0, sel_q=0, chg=0 immediately, no clock needed. Throughout, O still equals I[s].
- Select-only change: data 8'h0F, s=3 then s=4 -> O goes 1 then 0 combinationally. O_q follows one edge later, with chg=1 for one cycle.
- With MUX_8TO1_ONEHOT_EN defined, s=6 -> sel_onehot=8'h40. Without the macro, the build succeeds with no such port.
